// File: rtl/fifo_vr_pkt_arbiter.sv
// fifo_vr_pkt_arbiter: packet-aware round-robin arbiter sharing one valid-ready FIFO write port
module fifo_vr_pkt_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = $clog2(NUM_IN),
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     sync_rst,
  input  logic                     en,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  input  logic [NUM_IN-1:0]        data_in_last,
  input  logic [NUM_IN-1:0]        data_in_valid,
  output logic [NUM_IN-1:0]        data_in_ready,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_out_last,
  output logic                     data_out_valid,
  input  logic                     data_out_ready,
  output logic [ID_W-1:0]          grant_id,
  output logic                     grant_active,
  output logic [CNT_W-1:0]         status_pkt_count
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state;
  logic [ID_W-1:0] r_grant;
  logic [ID_W-1:0] r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [ID_W-1:0] w_sel;
  logic [ID_W-1:0] w_idx;
  logic w_found;
  logic w_busy;
  logic w_hs;
  // nearest valid requester after the pointer; scanning far-to-near lets the nearest overwrite
  always_comb begin
    w_sel = r_last;
    w_idx = '0;
    w_found = 1'b0;
    for (int k = NUM_IN; k >= 1; k--) begin
      w_idx = ID_W'((int'(r_last) + k) % NUM_IN);
      if (data_in_valid[w_idx]) begin
        w_found = 1'b1;
        w_sel = w_idx;
      end
    end
  end
  assign w_busy           = r_state == BUSY;
  assign data_out         = data_in[int'(r_grant)*DATA_W +: DATA_W];
  assign data_out_last    = data_in_last[r_grant];
  assign data_out_valid   = w_busy & en & data_in_valid[r_grant];
  assign data_in_ready    = (w_busy & en & data_out_ready) ? NUM_IN'(1) << r_grant : '0;
  assign w_hs             = data_out_valid & data_out_ready;
  assign grant_id         = r_grant;
  assign grant_active     = w_busy;
  assign status_pkt_count = r_cnt;
  // grant lock from arbitration until the last beat handshakes; everything freezes while en is low
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= ID_W'(NUM_IN - 1);
      r_cnt   <= '0;
    end else if (en) begin
      if (r_state == IDLE && w_found) begin
        r_state <= BUSY;
        r_grant <= w_sel;
        r_last  <= w_sel;
      end else if (w_busy && w_hs && data_out_last) begin
        r_state <= IDLE;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_fifo_vr_pkt_arbiter.sv
// tb_fifo_vr_pkt_arbiter: directed scenarios plus random traffic against a packet-queue reference model
module tb_fifo_vr_pkt_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int CW = 4;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sync_rst, en, data_out_last, data_out_valid, data_out_ready, grant_active;
  logic [N*DW-1:0] data_in;
  logic [N-1:0] data_in_last, data_in_valid, data_in_ready;
  logic [DW-1:0] data_out;
  logic [IW-1:0] grant_id;
  logic [CW-1:0] status_pkt_count;

  fifo_vr_pkt_arbiter #(.NUM_IN(N), .DATA_W(DW), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .sync_rst(sync_rst), .en(en),
    .data_in(data_in), .data_in_last(data_in_last), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .data_out(data_out), .data_out_last(data_out_last),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .grant_id(grant_id), .grant_active(grant_active), .status_pkt_count(status_pkt_count)
  );

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] mem_d [N][DEPTH];
  logic mem_l [N][DEPTH];
  int head [N];
  int tail [N];
  int pkt_no [N];
  logic [N-1:0] gate;
  logic rdy_i, en_i, rst_i;
  logic m_known, m_busy;
  int m_g, m_ptr;
  logic [CW-1:0] m_cnt;
  int order [$];
  logic prev_ga;
  int ncyc;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input int beats);
    for (int b = 0; b < beats; b++) begin
      mem_d[i][tail[i]] = {8'(i), 8'(pkt_no[i]), 16'(b)};
      mem_l[i][tail[i]] = (b == beats - 1);
      tail[i]++;
    end
    pkt_no[i]++;
  endtask

  function automatic logic pending();
    logic p = m_busy;
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) p = 1'b1;
    return p;
  endfunction

  task automatic step();
    logic [N-1:0] exp_rdy;
    logic exp_v;
    int best, bd, d;
    sync_rst = rst_i;
    en = en_i;
    data_out_ready = rdy_i;
    for (int i = 0; i < N; i++) begin
      data_in_valid[i] = (head[i] < tail[i]) & gate[i];
      data_in[i*DW +: DW] = (head[i] < tail[i]) ? mem_d[i][head[i]] : DW'($urandom);
      data_in_last[i] = (head[i] < tail[i]) ? mem_l[i][head[i]] : 1'($urandom);
    end
    #1;
    if (m_known) begin
      exp_rdy = (m_busy && en_i && rdy_i) ? N'(1) << m_g : '0;
      exp_v = m_busy & en_i & data_in_valid[m_g];
      chk("grant_active", grant_active, m_busy);
      chk("grant_id", grant_id, m_g);
      chk("in_ready", data_in_ready, exp_rdy);
      chk("out_valid", data_out_valid, exp_v);
      chk("pkt_count", status_pkt_count, m_cnt);
      if (exp_v) begin
        chk("out_data", data_out, mem_d[m_g][head[m_g]]);
        chk("out_last", data_out_last, mem_l[m_g][head[m_g]]);
      end
    end
    if (grant_active === 1'b1 && prev_ga !== 1'b1) order.push_back(int'(grant_id));
    prev_ga = grant_active;
    if (rst_i) begin
      m_known = 1'b1;
      m_busy = 1'b0;
      m_g = 0;
      m_ptr = N - 1;
      m_cnt = '0;
    end else if (en_i) begin
      if (!m_busy) begin
        best = -1;
        bd = N;
        for (int i = 0; i < N; i++) begin
          d = (i - m_ptr - 1 + 2 * N) % N;
          if (data_in_valid[i] && d < bd) begin
            bd = d;
            best = i;
          end
        end
        if (best >= 0) begin
          m_busy = 1'b1;
          m_g = best;
          m_ptr = best;
        end
      end else if (data_in_valid[m_g] && rdy_i) begin
        if (mem_l[m_g][head[m_g]]) begin
          m_busy = 1'b0;
          m_cnt = m_cnt + 1'b1;
        end
        head[m_g]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output int n);
    gate = '1;
    rdy_i = 1'b1;
    en_i = 1'b1;
    rst_i = 1'b0;
    n = 0;
    while (pending() && n < 500) begin
      step();
      n++;
    end
    if (pending()) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout cycles=%0d required=idle", n);
    end
  endtask

  task automatic chk_order(input string tag, input int n, input int e [5]);
    chk({tag, "_len"}, order.size(), n);
    for (int k = 0; k < n; k++) if (k < order.size()) chk(tag, order[k], e[k]);
    order.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
      pkt_no[i] = 0;
    end
    m_known = 1'b0;
    m_busy = 1'b0;
    m_g = 0;
    m_ptr = N - 1;
    m_cnt = '0;
    prev_ga = 1'b0;
    gate = '1;
    rdy_i = 1'b1;
    en_i = 1'b1;
    rst_i = 1'b1;
    load(0, 2); load(0, 2); load(1, 2); load(2, 2); load(3, 2);
    @(posedge clk);
    #1;
    step();
    step();
    chk("rst_active", grant_active, 1'b0);
    chk("rst_ready", data_in_ready, 4'b0);
    chk("rst_count", status_pkt_count, 4'd0);
    order.delete();
    drain(ncyc);
    chk("rr_cycles", ncyc, 15);
    chk("rr_count", status_pkt_count, 4'd5);
    chk_order("rr_order", 5, '{0, 1, 2, 3, 0});

    load(1, 4);
    step();
    step();
    load(0, 2);
    drain(ncyc);
    chk_order("nointerleave_order", 2, '{1, 0, 0, 0, 0});

    load(2, 4);
    step(); step(); step();
    rdy_i = 1'b0;
    step(); step(); step();
    drain(ncyc);
    chk_order("backpressure_order", 1, '{2, 0, 0, 0, 0});
    chk("bp_count", status_pkt_count, 4'd8);

    load(3, 4);
    step(); step();
    en_i = 1'b0;
    step(); step();
    drain(ncyc);
    chk_order("enable_order", 1, '{3, 0, 0, 0, 0});
    chk("en_count", status_pkt_count, 4'd9);

    for (int k = 0; k < 6; k++) load(k % N, 1);
    drain(ncyc);
    chk("count_15", status_pkt_count, 4'd15);
    load(1, 1);
    drain(ncyc);
    chk("count_wrap", status_pkt_count, 4'd0);
    order.delete();

    load(2, 4);
    step(); step(); step();
    rst_i = 1'b1;
    load(0, 1);
    load(1, 1);
    order.delete();
    step();
    chk("midrst_active", grant_active, 1'b0);
    chk("midrst_count", status_pkt_count, 4'd0);
    drain(ncyc);
    chk_order("midrst_order", 3, '{0, 1, 2, 0, 0});
    chk("midrst_final", status_pkt_count, 4'd3);

    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (tail[i] - head[i] < 6 && $urandom_range(0, 3) == 0) load(i, $urandom_range(1, 4));
      gate = N'($urandom);
      rdy_i = ($urandom_range(0, 3) != 0);
      en_i = ($urandom_range(0, 9) != 0);
      rst_i = ($urandom_range(0, 299) == 0);
      step();
    end
    drain(ncyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
